// File: rtl/adventure_pkg.sv
// Shared types for the adventure room FSM: room encoding and button bit positions.
package adventure_pkg;

  localparam int ROOM_N  = 7;
  localparam int NUM_BTN = 4;

  // Button vector is {n,s,e,w}
  localparam int BTN_W = 0;
  localparam int BTN_E = 1;
  localparam int BTN_S = 2;
  localparam int BTN_N = 3;

  typedef enum logic [2:0] {
    CAVE          = 3'd0,
    TUNNEL        = 3'd1,
    RIVER         = 3'd2,
    SWORD_STASH   = 3'd3,
    DRAGON_DEN    = 3'd4,
    VICTORY_VAULT = 3'd5,
    GRAVEYARD     = 3'd6
  } room_t;

  // One-hot room indicator; an out-of-range code decodes to all zeros.
  function automatic logic [ROOM_N-1:0] room_onehot(input room_t r);
    logic [ROOM_N-1:0] oh;
    oh = '0;
    for (int i = 0; i < ROOM_N; i++)
      if (r == room_t'(i)) oh[i] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/dir_press_detect.sv
// Rising-edge detect on the four direction buttons plus "exactly one press" qualifier.
module dir_press_detect
  import adventure_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] i_btn,
  output logic [NUM_BTN-1:0] o_press,
  output logic               o_press_valid
);

  logic [NUM_BTN-1:0] r_prev;
  logic [NUM_BTN-1:0] w_press;

  // Previous levels; reset to all ones so a button held across reset release is not a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_prev <= '1;
    else       r_prev <= i_btn;
  end

  assign w_press       = i_btn & ~r_prev;
  assign o_press       = w_press;
  assign o_press_valid = $onehot(w_press);

endmodule

// File: rtl/adventure_room_fsm.sv
// Room-navigation FSM: moves through the 7-room map on single button presses,
// resolves the dragon fight from the sword FSM's v, counts accepted moves.
module adventure_room_fsm
  import adventure_pkg::*;
#(
  parameter int MOVE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              n,
  input  logic              s,
  input  logic              e,
  input  logic              w,
  input  logic              v,
  output logic [ROOM_N-1:0] room,
  output logic              sw,
  output logic              win,
  output logic              dead,
  output logic [MOVE_W-1:0] moves
);

  room_t               r_state;
  room_t               w_next;
  logic                w_move;
  logic [NUM_BTN-1:0]  w_press;
  logic                w_press_valid;
  logic [NUM_BTN-1:0]  w_go;
  logic [MOVE_W-1:0]   r_moves;

  dir_press_detect u_press (
    .clk           (clk),
    .reset         (reset),
    .i_btn         ({n, s, e, w}),
    .o_press       (w_press),
    .o_press_valid (w_press_valid)
  );

  // Only a lone press steers the FSM; simultaneous presses are discarded.
  assign w_go = w_press & {NUM_BTN{w_press_valid}};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= CAVE;
    else       r_state <= w_next;
  end

  // Next-state: map exits; w_move flags a button-driven room change
  always_comb begin
    w_next = r_state;
    w_move = 1'b0;
    case (r_state)
      CAVE: begin
        if (w_go[BTN_E]) begin w_next = TUNNEL; w_move = 1'b1; end
      end
      TUNNEL: begin
        if (w_go[BTN_W])      begin w_next = CAVE;  w_move = 1'b1; end
        else if (w_go[BTN_S]) begin w_next = RIVER; w_move = 1'b1; end
      end
      RIVER: begin
        if (w_go[BTN_N])      begin w_next = TUNNEL;      w_move = 1'b1; end
        else if (w_go[BTN_W]) begin w_next = SWORD_STASH; w_move = 1'b1; end
        else if (w_go[BTN_E]) begin w_next = DRAGON_DEN;  w_move = 1'b1; end
      end
      SWORD_STASH: begin
        if (w_go[BTN_E]) begin w_next = RIVER; w_move = 1'b1; end
      end
      // Fight resolves on the next edge regardless of buttons; not counted as a move
      DRAGON_DEN:    w_next = v ? VICTORY_VAULT : GRAVEYARD;
      VICTORY_VAULT: w_next = VICTORY_VAULT;
      GRAVEYARD:     w_next = GRAVEYARD;
      default:       w_next = CAVE;
    endcase
  end

  // Saturating move counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        r_moves <= '0;
    else if (w_move && r_moves != '1) r_moves <= r_moves + MOVE_W'(1);
  end

  // Moore output decode
  always_comb begin
    room  = room_onehot(r_state);
    sw    = (r_state == SWORD_STASH);
    win   = (r_state == VICTORY_VAULT);
    dead  = (r_state == GRAVEYARD);
    moves = r_moves;
  end

endmodule

// File: tb/tb_adventure_room_fsm.sv
// Bench for adventure_room_fsm: directed scenarios plus random walks against a map-table model.
module tb_adventure_room_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       n = 1'b0, s = 1'b0, e = 1'b0, w = 1'b0;
  logic       v = 1'b0;
  logic [6:0] room, room2;
  logic       sw, win, dead, sw2, win2, dead2;
  logic [7:0] moves;
  logic [1:0] moves2;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         nxt [7][4];   // [room][button bit], -1 = no exit
  int         m_room;
  int         m_moves;      // unbounded; saturated at compare time
  logic [3:0] m_prev;
  logic       m_v;

  always #5 clk = ~clk;

  // Stand-in sword FSM: latches once sw is seen, cleared by the shared reset
  always @(posedge clk or posedge reset) begin
    if (reset)   v <= 1'b0;
    else if (sw) v <= 1'b1;
  end

  adventure_room_fsm #(.MOVE_W(8)) dut (
    .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w), .v(v),
    .room(room), .sw(sw), .win(win), .dead(dead), .moves(moves)
  );

  adventure_room_fsm #(.MOVE_W(2)) dut2 (
    .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w), .v(v),
    .room(room2), .sw(sw2), .win(win2), .dead(dead2), .moves(moves2)
  );

  task automatic model_reset();
    m_room  = 0;
    m_moves = 0;
    m_prev  = 4'hF;
    m_v     = 1'b0;
  endtask

  // One clock: advance the model with the levels present at the edge, return 1 after it
  task automatic tick();
    logic [3:0] cur, pr;
    int old;
    @(posedge clk);
    if (reset) model_reset();
    else begin
      cur    = {n, s, e, w};
      pr     = cur & ~m_prev;
      m_prev = cur;
      old    = m_room;
      if (old == 4) m_room = m_v ? 5 : 6;
      else if ($countones(pr) == 1) begin
        for (int d = 0; d < 4; d++)
          if (pr[d] && nxt[old][d] >= 0) begin
            m_room = nxt[old][d];
            m_moves++;
          end
      end
      if (old == 3) m_v = 1'b1;
    end
    #1;
  endtask

  task automatic press(input logic [3:0] b);
    {n, s, e, w} = b;
    tick();
    {n, s, e, w} = 4'b0000;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [17:0] got, exp;
    {n, s, e, w} = 4'b0000;
    do_reset();
    repeat (10) tick();
    got = {room, sw, win, dead, moves};
    exp = {7'b0000001, 1'b0, 1'b0, 1'b0, 8'd0};
    total++;
    if (got !== exp) begin bad++; $display("FAIL reset_state got=%h exp=%h", got, exp); end
  endtask

  task automatic test_sword_path();
    logic [17:0] got, exp;
    press(4'b0010);                  // E -> TUNNEL
    press(4'b0100);                  // S -> RIVER
    w = 1'b1;                        // W -> SWORD_STASH
    tick();
    got = {room, sw, win, dead, moves};
    exp = {7'b0001000, 1'b1, 1'b0, 1'b0, 8'd3};
    total++;
    if (got !== exp) begin bad++; $display("FAIL sword_stash got=%h exp=%h", got, exp); end
    total++;
    if (v !== 1'b0) begin bad++; $display("FAIL v_before_latch got=%b exp=0", v); end
    w = 1'b0;
    tick();
    total++;
    if (v !== 1'b1) begin bad++; $display("FAIL v_latched got=%b exp=1", v); end
  endtask

  task automatic test_victory();
    logic [17:0] got, exp;
    press(4'b0010);                  // E -> RIVER
    e = 1'b1;                        // E -> DRAGON_DEN
    tick();
    got = {room, sw, win, dead, moves};
    exp = {7'b0010000, 1'b0, 1'b0, 1'b0, 8'd5};
    total++;
    if (got !== exp) begin bad++; $display("FAIL den_with_sword got=%h exp=%h", got, exp); end
    e = 1'b0;
    tick();
    got = {room, sw, win, dead, moves};
    exp = {7'b0100000, 1'b0, 1'b1, 1'b0, 8'd5};
    total++;
    if (got !== exp) begin bad++; $display("FAIL victory got=%h exp=%h", got, exp); end
    press(4'b1000); press(4'b0100); press(4'b0010); press(4'b0001);
    got = {room, sw, win, dead, moves};
    total++;
    if (got !== exp) begin bad++; $display("FAIL victory_terminal got=%h exp=%h", got, exp); end
  endtask

  task automatic test_graveyard();
    logic [17:0] got, exp;
    do_reset();
    press(4'b0010);
    press(4'b0100);
    e = 1'b1;
    tick();
    got = {room, sw, win, dead, moves};
    exp = {7'b0010000, 1'b0, 1'b0, 1'b0, 8'd3};
    total++;
    if (got !== exp) begin bad++; $display("FAIL den_no_sword got=%h exp=%h", got, exp); end
    e = 1'b0;
    tick();
    got = {room, sw, win, dead, moves};
    exp = {7'b1000000, 1'b0, 1'b0, 1'b1, 8'd3};
    total++;
    if (got !== exp) begin bad++; $display("FAIL graveyard got=%h exp=%h", got, exp); end
    press(4'b0001);
    got = {room, sw, win, dead, moves};
    total++;
    if (got !== exp) begin bad++; $display("FAIL graveyard_terminal got=%h exp=%h", got, exp); end
  endtask

  task automatic test_press_rules();
    logic [17:0] got, exp;
    e = 1'b1;                        // held through reset release
    reset = 1'b1;
    model_reset();
    tick(); tick();
    reset = 1'b0;
    repeat (3) tick();
    got = {room, sw, win, dead, moves};
    exp = {7'b0000001, 1'b0, 1'b0, 1'b0, 8'd0};
    total++;
    if (got !== exp) begin bad++; $display("FAIL held_thru_reset got=%h exp=%h", got, exp); end
    e = 1'b0;
    tick();
    e = 1'b1;                        // re-press and hold 20 cycles
    repeat (20) tick();
    got = {room, sw, win, dead, moves};
    exp = {7'b0000010, 1'b0, 1'b0, 1'b0, 8'd1};
    total++;
    if (got !== exp) begin bad++; $display("FAIL held_one_move got=%h exp=%h", got, exp); end
    e = 1'b0;
    tick();
    press(4'b0110);                  // E+S together in TUNNEL
    got = {room, sw, win, dead, moves};
    total++;
    if (got !== exp) begin bad++; $display("FAIL dual_press got=%h exp=%h", got, exp); end
    press(4'b1000);                  // N has no exit from TUNNEL
    got = {room, sw, win, dead, moves};
    total++;
    if (got !== exp) begin bad++; $display("FAIL no_exit got=%h exp=%h", got, exp); end
  endtask

  task automatic test_saturate_reset();
    logic [9:0] got, exp;
    do_reset();
    for (int i = 0; i < 6; i++) press((i % 2 == 0) ? 4'b0010 : 4'b0001);
    got = {room2, moves2, moves[0] ? 1'b1 : 1'b0};
    exp = {7'b0000001, 2'd3, 1'b0};
    total++;
    if (got !== exp) begin bad++; $display("FAIL saturate got=%h exp=%h", got, exp); end
    total++;
    if (moves !== 8'd6) begin bad++; $display("FAIL wide_count got=%0d exp=6", moves); end
    e = 1'b1;
    tick();                          // into TUNNEL
    #2 reset = 1'b1;                 // mid-cycle, well before the next edge
    model_reset();
    #1;
    got = {room, moves2, 1'b0};
    exp = {7'b0000001, 2'd0, 1'b0};
    total++;
    if (got !== exp || moves !== 8'd0 || room2 !== 7'b0000001) begin
      bad++; $display("FAIL async_reset got=%h moves=%0d exp=%h moves=0", got, moves, exp);
    end
    e = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [17:0] got, exp;
    logic [11:0] got2, exp2;
    logic [6:0]  oh;
    int          mm;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (reset) reset = 1'b0;
      else if ($urandom_range(99) == 0) begin reset = 1'b1; model_reset(); end
      n = ($urandom_range(3) == 0);
      s = ($urandom_range(3) == 0);
      e = ($urandom_range(2) == 0);
      w = ($urandom_range(3) == 0);
      tick();
      oh   = 7'b0000001 << m_room;
      mm   = (m_moves > 255) ? 255 : m_moves;
      exp  = {oh, m_room == 3, m_room == 5, m_room == 6, 8'(mm)};
      got  = {room, sw, win, dead, moves};
      total++;
      if (got !== exp) begin bad++; $display("FAIL random_main cyc=%0d got=%h exp=%h", c, got, exp); end
      mm   = (m_moves > 3) ? 3 : m_moves;
      exp2 = {oh, m_room == 3, m_room == 5, m_room == 6, 2'(mm)};
      got2 = {room2, sw2, win2, dead2, moves2};
      total++;
      if (got2 !== exp2) begin bad++; $display("FAIL random_narrow cyc=%0d got=%h exp=%h", c, got2, exp2); end
    end
    reset = 1'b0;
  endtask

  initial begin
    for (int r = 0; r < 7; r++) for (int d = 0; d < 4; d++) nxt[r][d] = -1;
    nxt[0][1] = 1;                               // CAVE E
    nxt[1][0] = 0; nxt[1][2] = 2;                // TUNNEL W,S
    nxt[2][3] = 1; nxt[2][0] = 3; nxt[2][1] = 4; // RIVER N,W,E
    nxt[3][1] = 2;                               // SWORD_STASH E
    model_reset();
    test_reset();
    test_sword_path();
    test_victory();
    test_graveyard();
    test_press_rules();
    test_saturate_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
